// File: rtl/snake_pkg.sv
`default_nettype none
// ============================================================================
// Package     : snake_pkg
// Description : Shared direction constants, FSM state encoding and direction
//               helpers for the snake game datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package snake_pkg;

    // One-hot direction codes as delivered by the button block
    localparam logic [3:0] DIR_UP    = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    // 180-degree counterpart of a heading; non one-hot input maps to 0
    function automatic logic [3:0] opposite_dir(input logic [3:0] dir);
        logic [3:0] opp;
        case (dir)
            DIR_UP:    opp = DIR_DOWN;
            DIR_DOWN:  opp = DIR_UP;
            DIR_LEFT:  opp = DIR_RIGHT;
            DIR_RIGHT: opp = DIR_LEFT;
            default:   opp = 4'b0000;
        endcase
        return opp;
    endfunction

    // A direction request is only meaningful with exactly one bit set
    function automatic logic dir_valid(input logic [3:0] dir);
        return $onehot(dir);
    endfunction

endpackage
`default_nettype wire

// File: rtl/move_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : move_tick_gen
// Description : Free-running move-rate divider. Counts 0..TICK_DIV-1 while
//               enabled and emits a one-cycle terminal-count pulse; the count
//               is forced to zero whenever the enable is low.
// Revision    : 1.0 - initial release
// ============================================================================
module move_tick_gen #(
    parameter int TICK_DIV = 25_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tc
);

    localparam int            CW     = $clog2(TICK_DIV);
    localparam logic [CW-1:0] c_last = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_count;

    // Divider counter: cleared while disabled, wraps at the terminal count
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    // Gate with en so a stale count can never fire a tick outside RUN
    assign tc = en && (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/head_position_stepper.sv
`default_nettype none
// ============================================================================
// Module      : head_position_stepper
// Description : Turns the latched one-hot direction bus into snake-head motion
//               on a GRID_W x GRID_H grid, one cell per move tick, rejecting
//               reversals and handling walls by wrap-around or game over.
// Revision    : 1.0 - initial release
// ============================================================================
module head_position_stepper
    import snake_pkg::*;
#(
    parameter int GRID_W   = 32,
    parameter int GRID_H   = 24,
    parameter int TICK_DIV = 25_000_000,
    parameter int START_X  = 16,
    parameter int START_Y  = 12,
    parameter int WRAP     = 0
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [3:0]                direction,
    input  logic                      start,
    input  logic                      collide,
    output logic [$clog2(GRID_W)-1:0] head_x,
    output logic [$clog2(GRID_H)-1:0] head_y,
    output logic [3:0]                heading,
    output logic                      move_pulse,
    output logic                      game_over
);

    localparam int XW = $clog2(GRID_W);
    localparam int YW = $clog2(GRID_H);

    localparam logic [XW-1:0] c_x_max   = XW'(GRID_W - 1);
    localparam logic [YW-1:0] c_y_max   = YW'(GRID_H - 1);
    localparam logic [XW-1:0] c_x_start = XW'(START_X);
    localparam logic [YW-1:0] c_y_start = YW'(START_Y);

    state_t        r_state, w_state_nx;
    logic [XW-1:0] r_x, w_x_nx, w_step_x;
    logic [YW-1:0] r_y, w_y_nx, w_step_y;
    logic [3:0]    r_heading, w_heading_nx, w_heading_cand;
    logic          r_move, w_move_nx;
    logic          w_wall;
    logic          w_run;
    logic          w_tc;

    assign w_run = (r_state == RUN);

    move_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .en  (w_run),
        .tc  (w_tc)
    );

    // Candidate heading and one-cell step; step values are already wrapped
    // and w_wall flags that the unwrapped move would leave the grid
    always_comb begin
        w_heading_cand = r_heading;
        if (dir_valid(direction) && (direction != opposite_dir(r_heading))) begin
            w_heading_cand = direction;
        end
        w_step_x = r_x;
        w_step_y = r_y;
        w_wall   = 1'b0;
        case (w_heading_cand)
            DIR_UP: begin
                if (r_y == '0) begin
                    w_wall   = 1'b1;
                    w_step_y = c_y_max;
                end else begin
                    w_step_y = r_y - YW'(1);
                end
            end
            DIR_DOWN: begin
                if (r_y == c_y_max) begin
                    w_wall   = 1'b1;
                    w_step_y = '0;
                end else begin
                    w_step_y = r_y + YW'(1);
                end
            end
            DIR_LEFT: begin
                if (r_x == '0) begin
                    w_wall   = 1'b1;
                    w_step_x = c_x_max;
                end else begin
                    w_step_x = r_x - XW'(1);
                end
            end
            DIR_RIGHT: begin
                if (r_x == c_x_max) begin
                    w_wall   = 1'b1;
                    w_step_x = '0;
                end else begin
                    w_step_x = r_x + XW'(1);
                end
            end
            default: begin
                w_wall = 1'b0;
            end
        endcase
    end

    // Next-state and next-output logic; collide takes priority over a tick
    always_comb begin
        w_state_nx   = r_state;
        w_x_nx       = r_x;
        w_y_nx       = r_y;
        w_heading_nx = r_heading;
        w_move_nx    = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nx = RUN;
                end
            end
            RUN: begin
                if (collide) begin
                    w_state_nx = DEAD;
                end else if (w_tc) begin
                    w_heading_nx = w_heading_cand;
                    if (w_wall && (WRAP == 0)) begin
                        w_state_nx = DEAD;
                    end else begin
                        w_x_nx    = w_step_x;
                        w_y_nx    = w_step_y;
                        w_move_nx = 1'b1;
                    end
                end
            end
            DEAD: begin
                if (start) begin
                    w_state_nx   = RUN;
                    w_x_nx       = c_x_start;
                    w_y_nx       = c_y_start;
                    w_heading_nx = DIR_RIGHT;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // State, position, heading and move strobe registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_x       <= c_x_start;
            r_y       <= c_y_start;
            r_heading <= DIR_RIGHT;
            r_move    <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_x       <= w_x_nx;
            r_y       <= w_y_nx;
            r_heading <= w_heading_nx;
            r_move    <= w_move_nx;
        end
    end

    assign head_x     = r_x;
    assign head_y     = r_y;
    assign heading    = r_heading;
    assign move_pulse = r_move;
    assign game_over  = (r_state == DEAD);

endmodule
`default_nettype wire
